// File: rtl/pc_core_dram_rd_arbiter.sv
// pc_core_dram_rd_arbiter
// Shares the single dram0_axi read channel between NUM_REQ read engines.
// AR requests are granted round-robin into a one-deep output register. An
// in-order grant FIFO records the owner of every granted burst so that the
// returning R beats can be steered back to the correct requester.
module pc_core_dram_rd_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                ap_clk,
  input  logic                                areset,
  input  logic [NUM_REQ-1:0]                  s_arvalid,
  output logic [NUM_REQ-1:0]                  s_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       s_araddr,
  input  logic [NUM_REQ*8-1:0]                s_arlen,
  output logic [NUM_REQ-1:0]                  s_rvalid,
  input  logic [NUM_REQ-1:0]                  s_rready,
  output logic [DATA_WIDTH-1:0]               s_rdata,
  output logic                                s_rlast,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  output logic [ADDR_WIDTH-1:0]               m_araddr,
  output logic [7:0]                          m_arlen,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  input  logic [DATA_WIDTH-1:0]               m_rdata,
  input  logic                                m_rlast,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                idle,
  output logic                                rd_err
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = PW + 1;
  localparam logic [IW-1:0] RR_INIT  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

  logic [IW-1:0]         rr;
  logic [IW-1:0]         grant;
  logic                  grant_found;
  logic                  load_en;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [IW-1:0]         fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [IW-1:0]         head;
  logic                  head_ready;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign load_en    = (!m_arvalid || m_arready) && !fifo_full;
  assign push       = load_en && grant_found;
  assign head       = fifo_mem[rd_ptr];

  // Round-robin search starting one past the last winner, wrapping at NUM_REQ
  always_comb begin
    grant       = rr;
    grant_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && s_arvalid[j] && (j == (32'(rr) + k) % NUM_REQ)) begin
          grant       = IW'(j);
          grant_found = 1'b1;
        end
      end
    end
  end

  // Select the winning requester's address/length and form the one-hot ready
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    s_arready = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant == IW'(j)) begin
        sel_addr = s_araddr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = s_arlen[j*8 +: 8];
      end
      s_arready[j] = push && (grant == IW'(j));
    end
  end

  // Steer R beats to the requester at the head of the grant FIFO
  always_comb begin
    s_rvalid   = '0;
    head_ready = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (head == IW'(j)) begin
        head_ready  = s_rready[j];
        s_rvalid[j] = m_rvalid && !fifo_empty;
      end
    end
  end

  assign m_rready = !fifo_empty && head_ready;
  assign s_rdata  = m_rdata;
  assign s_rlast  = m_rlast;
  assign pop      = m_rvalid && m_rready && m_rlast;

  // AR output register and round-robin pointer; held until m_arready
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      rr        <= RR_INIT;
    end else if (push) begin
      m_arvalid <= 1'b1;
      m_araddr  <= sel_addr;
      m_arlen   <= sel_len;
      rr        <= grant;
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  // Grant FIFO storage; owner id written at grant time
  always_ff @(posedge ap_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= grant;
    end
  end

  // Grant FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Sticky error: read data arriving with no burst outstanding
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      rd_err <= 1'b0;
    end else if (m_rvalid && fifo_empty) begin
      rd_err <= 1'b1;
    end
  end

  assign outstanding = count;
  assign idle        = fifo_empty && !m_arvalid;

endmodule

// File: tb/tb_pc_core_dram_rd_arbiter.sv
// Testbench for pc_core_dram_rd_arbiter: randomized requesters and a DRAM
// responder, with a scoreboard/monitor holding a transaction-level model of
// grants, outstanding bursts and beat ownership.
module tb_pc_core_dram_rd_arbiter;
  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 8;

  logic            ap_clk = 1'b0;
  logic            areset = 1'b1;
  logic [NR-1:0]   s_arvalid = '0;
  logic [NR-1:0]   s_arready;
  logic [NR*AW-1:0] s_araddr = '0;
  logic [NR*8-1:0] s_arlen = '0;
  logic [NR-1:0]   s_rvalid;
  logic [NR-1:0]   s_rready = '0;
  logic [DW-1:0]   s_rdata;
  logic            s_rlast;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic [DW-1:0]   m_rdata = '0;
  logic            m_rlast = 1'b0;
  logic [3:0]      outstanding;
  logic            idle;
  logic            rd_err;

  pc_core_dram_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .ap_clk(ap_clk), .areset(areset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .outstanding(outstanding), .idle(idle), .rd_err(rd_err)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {logic [31:0] addr; logic [7:0] len;} req_t;
  typedef struct packed {logic [31:0] data; logic last;} beat_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int unsigned b);
    return a ^ (b * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.addr = $urandom & 32'hFFFF_FFC0;
    r.len  = 8'($urandom_range(3));
    return r;
  endfunction

  // Stimulus-side state
  req_t        pend [NR][$];
  req_t        dram_q[$];
  bit          acc [NR];
  bit          cur_v [NR];
  bit          r_took = 0;
  bit          rv_cur = 0;
  int unsigned beat = 0;
  int unsigned arv_pct = 100, arr_pct = 100, rv_pct = 100, rr_pct = 100;
  bit          r_en = 1, stray = 0;

  // Reference model state (transaction level)
  int unsigned m_count = 0;
  bit          slot_busy = 0;
  req_t        slot_req;
  int unsigned last_g = NR - 1;
  int unsigned owner_q[$];
  beat_t       exp_r [NR][$];
  bit          rderr_m = 0;

  // Scoreboard/monitor: predicts each cycle's outputs and consumes handshakes
  always @(negedge ap_clk) begin : mon
    logic [1:0]  exp_ready, exp_rv;
    bit          can, g, mrr, rhs;
    int unsigned w, own;
    req_t        r;
    beat_t       e;
    if (areset) begin
      m_count = 0; slot_busy = 0; last_g = NR - 1; rderr_m = 0;
      owner_q.delete(); exp_r[0].delete(); exp_r[1].delete();
      acc[0] = 0; acc[1] = 0; r_took = 0;
    end else begin
      can = (!slot_busy || m_arready) && (m_count < MO);
      g = 0; w = 0;
      if (can && s_arvalid != 2'b00) begin
        g = 1;
        if (s_arvalid == 2'b11) w = (last_g == 0) ? 1 : 0;
        else                    w = s_arvalid[1] ? 1 : 0;
      end
      exp_ready = g ? (2'b01 << w) : 2'b00;
      check("s_arready", s_arready, exp_ready);
      check("m_arvalid", m_arvalid, slot_busy);
      if (slot_busy) begin
        check("m_araddr", m_araddr, slot_req.addr);
        check("m_arlen", m_arlen, slot_req.len);
      end
      check("outstanding", outstanding, m_count);
      check("idle", idle, (m_count == 0) && !slot_busy);
      check("rd_err", rd_err, rderr_m);
      own    = (m_count > 0) ? owner_q[0] : 0;
      exp_rv = (m_rvalid && m_count > 0) ? (2'b01 << own) : 2'b00;
      mrr    = (m_count > 0) && s_rready[own];
      check("s_rvalid", s_rvalid, exp_rv);
      check("m_rready", m_rready, mrr);
      rhs = m_rvalid && mrr;
      if (rhs) begin
        if (exp_r[own].size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL r_beat: unexpected beat for requester %0d at %0t", own, $time);
        end else begin
          e = exp_r[own].pop_front();
          check("s_rdata", s_rdata, e.data);
          check("s_rlast", s_rlast, e.last);
        end
        r_took = 1;
      end
      if (m_rvalid && m_count == 0) rderr_m = 1;
      if (slot_busy && m_arready) begin
        dram_q.push_back(slot_req);
        if (!g) slot_busy = 0;
      end
      if (g) begin
        r = pend[w][0];
        slot_req = r; slot_busy = 1; acc[w] = 1; last_g = w;
        owner_q.push_back(w);
        for (int unsigned b = 0; b <= r.len; b++)
          exp_r[w].push_back({beat_data(r.addr, b), b == r.len});
      end
      if (rhs && m_rlast) void'(owner_q.pop_front());
      m_count = m_count + (g ? 1 : 0) - ((rhs && m_rlast) ? 1 : 0);
    end
  end

  // One stimulus cycle: consume handshakes, then drive requesters and DRAM
  task automatic step();
    @(posedge ap_clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        void'(pend[i].pop_front());
        acc[i] = 0; cur_v[i] = 0;
      end
    end
    if (r_took) begin
      r_took = 0; rv_cur = 0;
      if (beat == dram_q[0].len) begin
        void'(dram_q.pop_front());
        beat = 0;
      end else beat++;
    end
    for (int i = 0; i < NR; i++) begin
      if (!cur_v[i] && pend[i].size() > 0 && $urandom_range(99) < arv_pct) cur_v[i] = 1;
      s_arvalid[i] = cur_v[i];
      if (pend[i].size() > 0) begin
        s_araddr[i*AW +: AW] = pend[i][0].addr;
        s_arlen[i*8 +: 8]    = pend[i][0].len;
      end
      s_rready[i] = ($urandom_range(99) < rr_pct);
    end
    m_arready = ($urandom_range(99) < arr_pct);
    if (stray) begin
      m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; m_rlast = 1;
    end else begin
      if (!rv_cur && r_en && dram_q.size() > 0 && $urandom_range(99) < rv_pct) rv_cur = 1;
      m_rvalid = rv_cur;
      if (rv_cur) begin
        m_rdata = beat_data(dram_q[0].addr, beat);
        m_rlast = (beat == dram_q[0].len);
      end
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (!(pend[0].size() == 0 && pend[1].size() == 0 && dram_q.size() == 0 &&
             m_count == 0 && !slot_busy) && n < 3000) begin
      step(); n++;
    end
    if (n >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: traffic did not complete within %0d cycles", n);
    end
  endtask

  task automatic do_reset();
    @(posedge ap_clk); #1;
    areset = 1;
    pend[0].delete(); pend[1].delete(); dram_q.delete();
    cur_v[0] = 0; cur_v[1] = 0; acc[0] = 0; acc[1] = 0;
    rv_cur = 0; r_took = 0; beat = 0;
    s_arvalid = '0; m_rvalid = 0; m_arready = 0;
    repeat (2) @(posedge ap_clk);
    #1 areset = 0;
  endtask

  task automatic reset_checks(input string tag);
    @(negedge ap_clk);
    check({tag, "_idle"}, idle, 1);
    check({tag, "_outstanding"}, outstanding, 0);
    check({tag, "_rd_err"}, rd_err, 0);
    check({tag, "_m_arvalid"}, m_arvalid, 0);
    check({tag, "_m_araddr"}, m_araddr, 0);
    check({tag, "_m_arlen"}, m_arlen, 0);
  endtask

  initial begin
    req_t r;
    repeat (3) @(posedge ap_clk);
    #1 areset = 0;
    reset_checks("reset");

    // Simultaneous requests: requester 0 first, then 1; beats split 4/4
    r.addr = 32'h1000; r.len = 8'd3; pend[0].push_back(r);
    r.addr = 32'h2000; r.len = 8'd3; pend[1].push_back(r);
    drain();

    // Both held valid: alternating grants; then requester 1 alone back to back
    for (int k = 0; k < 3; k++) begin
      pend[0].push_back(rnd_req());
      pend[1].push_back(rnd_req());
    end
    drain();
    for (int k = 0; k < 4; k++) pend[1].push_back(rnd_req());
    drain();

    // Randomized traffic with backpressure on every interface
    arv_pct = 60; arr_pct = 70; rv_pct = 70; rr_pct = 70;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NR; i++)
        if (pend[i].size() < 4 && $urandom_range(3) == 0) pend[i].push_back(rnd_req());
      step();
    end
    drain();

    // Fill to MAX_OUTSTANDING with R withheld, then release
    arv_pct = 100; arr_pct = 100; rv_pct = 100; rr_pct = 100; r_en = 0;
    for (int k = 0; k < 6; k++) begin
      pend[0].push_back(rnd_req());
      pend[1].push_back(rnd_req());
    end
    repeat (20) step();
    @(negedge ap_clk);
    check("full_outstanding", outstanding, MO);
    check("full_arready", s_arready, 0);
    r_en = 1;
    drain();

    // AR held stable while m_arready is low
    arr_pct = 0;
    for (int k = 0; k < 2; k++) begin
      pend[0].push_back(rnd_req());
      pend[1].push_back(rnd_req());
    end
    repeat (12) step();
    arr_pct = 100;
    drain();

    // Stray read data with nothing outstanding: sticky error, stalled ready
    stray = 1;
    repeat (2) step();
    stray = 0;
    repeat (3) step();
    @(negedge ap_clk);
    check("rd_err_sticky", rd_err, 1);

    // Reset in the middle of traffic
    arv_pct = 70; arr_pct = 70; rv_pct = 70; rr_pct = 70;
    for (int k = 0; k < 4; k++) begin
      pend[0].push_back(rnd_req());
      pend[1].push_back(rnd_req());
    end
    repeat (10) step();
    do_reset();
    reset_checks("midreset");

    for (int k = 0; k < 200; k++) begin
      for (int i = 0; i < NR; i++)
        if (pend[i].size() < 3 && $urandom_range(3) == 0) pend[i].push_back(rnd_req());
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
